imem_ctrl: RTL and testbench
============================

Name: imem_ctrl

Overview:
- Owns the single port of the instruction memory and shares it between the CPU fetch stage and a program loader (boot/debug write path).
- After reset it holds the CPU in BOOT while the loader fills memory, then switches to RUN and serves fetches with a registered 1-cycle read.
- It sits between the fetch stage, the loader and the combinational-read, word-addressed instruction memory array.

Parameters:
- IMEM_SIZE, 1024, memory depth in 32-bit words (same value as the shared `IMEM_SIZE` define).
- ADDR_W, 10, word-index width; must equal clog2(IMEM_SIZE).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ld_valid  input  1  loader presents a write.
- ld_ready  output  1  controller accepts the loader write this cycle.
- ld_addr  input  32  loader byte address.
- ld_data  input  32  loader write word.
- ld_done  input  1  loader end-of-image pulse.
- if_req  input  1  fetch request.
- if_addr  input  32  fetch byte address (PC).
- if_gnt  output  1  fetch accepted this cycle.
- if_valid  output  1  if_instr holds the word for the fetch granted last cycle.
- if_instr  output  32  fetched instruction, registered.
- if_err  output  1  registered error flag for the fetch granted last cycle.
- mem_addr  output  ADDR_W  word index to the memory array.
- mem_we  output  1  memory write enable.
- mem_wdata  output  32  memory write data.
- mem_rdata  input  32  combinational read data from the array.
- cpu_run  output  1  high in RUN; releases the CPU PC.
- boot_words  output  ADDR_W+1  count of loader words accepted since reset.

Behaviour:
- Reset values (async, rst_n=0):
  - state=BOOT.
  - if_valid=0, if_instr=0, if_err=0, cpu_run=0, boot_words=0.
  - Combinational outputs follow from state=BOOT.
- States: BOOT, RUN.
- BOOT:
  - ld_ready=1 and if_gnt=0.
  - An accepted write (ld_valid & ld_ready) drives mem_we=1, mem_addr=ld_addr[ADDR_W+1:2], mem_wdata=ld_data, and increments boot_words.
- BOOT -> RUN on the clock edge after either of:
  - ld_done=1;
  - a write that brings boot_words to IMEM_SIZE.
  - ld_done together with a write in the same cycle: the write is performed, then the transition happens.
  - cpu_run rises in the same edge.
- RUN, loader priority:
  - ld_ready=1 always, so the loader has priority.
  - When ld_valid=1: the write proceeds, if_gnt=0, and the fetch retries.
  - boot_words saturates at IMEM_SIZE and does not wrap.
- RUN, fetch grant:
  - if_gnt = if_req & ~ld_valid.
  - While granted: mem_we=0 and mem_addr=if_addr[ADDR_W+1:2].
  - Next edge: if_instr<=mem_rdata, if_valid<=1.
  - Fixed 1-cycle latency; back-to-back fetches give one word per cycle.
- Fetch error:
  - if_err<=1 on a granted fetch with if_addr[1:0]!=0 or if_addr[31:ADDR_W+2]!=0.
  - On error, if_instr<=32'h0000_0000 (NOP) and if_valid<=1.
- When no fetch is granted: if_valid<=0 and if_err<=0; if_instr holds its value.
- Loader writes with misaligned or out-of-range addresses:
  - are accepted and dropped (mem_we=0);
  - still count in boot_words.
- Idle (no requester): mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: immediate return to BOOT. Memory contents are not cleared (the array has no reset).
- ld_done in RUN is ignored.
- There is no RUN -> BOOT path except reset.

Decomposition:
- Shared package / defines:
  - `IMEM_SIZE`;
  - state encoding localparams ST_BOOT=1'b0, ST_RUN=1'b1;
  - NOP constant 32'h0000_0000.
- No sub-module is needed. Arbitration and the FSM are a single always block plus combinational muxing.
- The memory array stays in its existing module, extended with a write port (we/wdata), clocked by clk.

Test Plan:
- Boot fill: reset, write 4 words 0x11111111..0x44444444 at byte addresses 0x0,0x4,0x8,0xC, then pulse ld_done.
  - Expected: boot_words=4, cpu_run=1 one cycle after ld_done, if_gnt stayed 0 throughout BOOT.
- Sequential fetch: in RUN, if_req=1 with if_addr 0x0,0x4,0x8 on consecutive cycles.
  - Expected: if_gnt=1 each cycle, if_valid=1 one cycle later, if_instr=0x11111111,0x22222222,0x33333333, no bubbles.
- Collision: in RUN, ld_valid=1 (addr 0x4, data 0xDEADBEEF) together with if_req=1 at 0x4.
  - Expected: if_gnt=0 and write done; retry next cycle returns if_instr=0xDEADBEEF.
- Errors: fetch at 0x2 and at 0x1000 (IMEM_SIZE=1024).
  - Expected: if_err=1, if_valid=1, if_instr=0 for each; fetch at 0x8 afterwards has if_err=0.
- Full fill: write 1024 words without ld_done.
  - Expected: cpu_run rises after the 1024th write; a further write leaves boot_words=1024.
- Async reset: assert rst_n=0 mid-fetch stream, between clock edges.
  - Expected: if_valid=0, cpu_run=0, boot_words=0 immediately; after release if_gnt=0 until a new ld_done; memory word at 0x0 still reads 0x11111111 after re-boot.

Source files
------------

// File: rtl/imem_ctrl_pkg.sv
// Shared constants and types for the instruction-memory controller.
`ifndef IMEM_SIZE
`define IMEM_SIZE 1024
`endif

package imem_ctrl_pkg;

  localparam int unsigned IMEM_SIZE = `IMEM_SIZE;
  localparam int unsigned ADDR_W    = $clog2(IMEM_SIZE);

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_ctrl_mem.sv
// Word-addressed instruction memory: combinational read, clocked write, no reset.
module imem_ctrl_mem #(
  parameter int unsigned IMEM_SIZE = imem_ctrl_pkg::IMEM_SIZE,
  parameter int unsigned ADDR_W    = imem_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [IMEM_SIZE];

  // Write port
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read port
  assign rdata = mem[addr];

endmodule

// File: rtl/imem_ctrl.sv
// Arbitrates the instruction-memory port between the loader and CPU fetch.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_SIZE = imem_ctrl_pkg::IMEM_SIZE,
  parameter int unsigned ADDR_W    = imem_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [31:0]       ld_data,
  input  logic              ld_done,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic              if_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              cpu_run,
  output logic [ADDR_W:0]   boot_words
);

  localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(IMEM_SIZE);
  localparam logic [ADDR_W:0] WORDS_ONE = (ADDR_W+1)'(1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   boot_words_q, boot_words_d;
  logic              if_valid_q, if_valid_d;
  logic              if_err_q, if_err_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              cpu_run_q, cpu_run_d;
  logic              ld_in_range;
  logic              if_in_range;

  // Address legality: word aligned and inside the array
  assign ld_in_range = (ld_addr[1:0] == 2'b00) && (ld_addr[31:ADDR_W+2] == '0);
  assign if_in_range = (if_addr[1:0] == 2'b00) && (if_addr[31:ADDR_W+2] == '0);

  // Next-state, arbitration and memory-port muxing; loader always wins
  always_comb begin
    state_d      = state_q;
    boot_words_d = boot_words_q;
    if_valid_d   = 1'b0;
    if_err_d     = 1'b0;
    if_instr_d   = if_instr_q;
    ld_ready     = 1'b1;
    if_gnt       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;

    if (ld_valid) begin
      // Bad addresses are accepted and counted, but never reach the array
      mem_addr  = ld_addr[ADDR_W+1:2];
      mem_we    = ld_in_range;
      mem_wdata = ld_in_range ? ld_data : '0;
      if (boot_words_q != WORDS_MAX) boot_words_d = boot_words_q + WORDS_ONE;
    end

    case (state_q)
      ST_BOOT: begin
        if (ld_done || (ld_valid && (boot_words_q == WORDS_MAX - WORDS_ONE))) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (if_req && !ld_valid) begin
          if_gnt     = 1'b1;
          mem_addr   = if_addr[ADDR_W+1:2];
          if_valid_d = 1'b1;
          if_err_d   = !if_in_range;
          if_instr_d = if_in_range ? mem_rdata : NOP;
        end
      end
      default: state_d = ST_BOOT;
    endcase

    cpu_run_d = (state_d == ST_RUN);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      boot_words_q <= '0;
      if_valid_q   <= 1'b0;
      if_err_q     <= 1'b0;
      if_instr_q   <= '0;
      cpu_run_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_words_q <= boot_words_d;
      if_valid_q   <= if_valid_d;
      if_err_q     <= if_err_d;
      if_instr_q   <= if_instr_d;
      cpu_run_q    <= cpu_run_d;
    end
  end

  assign if_valid   = if_valid_q;
  assign if_err     = if_err_q;
  assign if_instr   = if_instr_q;
  assign cpu_run    = cpu_run_q;
  assign boot_words = boot_words_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl with the instruction array attached.
`timescale 1ns/1ps
module tb_imem_ctrl;
  import imem_ctrl_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              ld_valid;
  logic              ld_ready;
  logic [31:0]       ld_addr;
  logic [31:0]       ld_data;
  logic              ld_done;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_valid;
  logic [31:0]       if_instr;
  logic              if_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              cpu_run;
  logic [ADDR_W:0]   boot_words;

  int checks;
  int failures;

  imem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_done(ld_done),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_instr(if_instr), .if_err(if_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_run(cpu_run), .boot_words(boot_words)
  );

  imem_ctrl_mem u_mem (
    .clk(clk), .addr(mem_addr), .we(mem_we), .wdata(mem_wdata), .rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    if_req = 1'b0; if_addr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    if_req = 1'b1;
    rst_n = 1'b0;
    #3;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rst_if_valid got=%0h exp=0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL rst_if_instr got=%08h exp=00000000", if_instr); end
    checks++; if (if_err !== 1'b0) begin failures++; $display("FAIL rst_if_err got=%0h exp=0", if_err); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL rst_cpu_run got=%0h exp=0", cpu_run); end
    checks++; if (boot_words !== 11'd0) begin failures++; $display("FAIL rst_boot_words got=%0d exp=0", boot_words); end
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL rst_ld_ready got=%0h exp=1", ld_ready); end
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL rst_if_gnt got=%0h exp=0", if_gnt); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wdata !== 32'h0) begin
      failures++; $display("FAIL rst_idle_port got we=%0h addr=%0h wdata=%08h exp we=0 addr=0 wdata=0", mem_we, mem_addr, mem_wdata);
    end
    tick();
    rst_n = 1'b1;
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_boot_fill();
    logic [31:0] words [4];
    words[0] = 32'h1111_1111; words[1] = 32'h2222_2222;
    words[2] = 32'h3333_3333; words[3] = 32'h4444_4444;
    if_req = 1'b1; if_addr = 32'h0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 32'(i * 4); ld_data = words[i];
      #1;
      checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL boot_gnt[%0d] got=%0h exp=0", i, if_gnt); end
      checks++; if (mem_we !== 1'b1 || mem_addr !== 10'(i) || mem_wdata !== words[i]) begin
        failures++; $display("FAIL boot_write[%0d] got we=%0h addr=%0h data=%08h exp we=1 addr=%0h data=%08h", i, mem_we, mem_addr, mem_wdata, i, words[i]);
      end
      tick();
    end
    ld_valid = 1'b0;
    checks++; if (boot_words !== 11'd4) begin failures++; $display("FAIL boot_count got=%0d exp=4", boot_words); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL boot_run_early got=%0h exp=0", cpu_run); end
    ld_done = 1'b1;
    #1;
    checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL boot_gnt_done got=%0h exp=0", if_gnt); end
    tick();
    ld_done = 1'b0; if_req = 1'b0;
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL boot_run got=%0h exp=1", cpu_run); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL boot_no_fetch got=%0h exp=0", if_valid); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_w [3];
    exp_w[0] = 32'h1111_1111; exp_w[1] = 32'h2222_2222; exp_w[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = 32'(i * 4);
      #1;
      checks++; if (if_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'(i)) begin
        failures++; $display("FAIL seq_gnt[%0d] got gnt=%0h we=%0h addr=%0h exp gnt=1 we=0 addr=%0h", i, if_gnt, mem_we, mem_addr, i);
      end
      tick();
      checks++; if (if_valid !== 1'b1 || if_err !== 1'b0 || if_instr !== exp_w[i]) begin
        failures++; $display("FAIL seq_data[%0d] got v=%0h e=%0h instr=%08h exp v=1 e=0 instr=%08h", i, if_valid, if_err, if_instr, exp_w[i]);
      end
    end
    if_req = 1'b0;
    tick();
    checks++; if (if_valid !== 1'b0 || if_instr !== 32'h3333_3333) begin
      failures++; $display("FAIL seq_hold got v=%0h instr=%08h exp v=0 instr=33333333", if_valid, if_instr);
    end
  endtask

  task automatic test_collision();
    ld_valid = 1'b1; ld_addr = 32'h4; ld_data = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h4;
    #1;
    checks++; if (if_gnt !== 1'b0 || ld_ready !== 1'b1) begin
      failures++; $display("FAIL col_gnt got gnt=%0h rdy=%0h exp gnt=0 rdy=1", if_gnt, ld_ready);
    end
    checks++; if (mem_we !== 1'b1 || mem_addr !== 10'd1 || mem_wdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL col_write got we=%0h addr=%0h data=%08h exp we=1 addr=1 data=deadbeef", mem_we, mem_addr, mem_wdata);
    end
    tick();
    ld_valid = 1'b0;
    checks++; if (if_valid !== 1'b0 || boot_words !== 11'd5) begin
      failures++; $display("FAIL col_count got v=%0h bw=%0d exp v=0 bw=5", if_valid, boot_words);
    end
    #1;
    checks++; if (if_gnt !== 1'b1) begin failures++; $display("FAIL col_retry_gnt got=%0h exp=1", if_gnt); end
    tick();
    if_req = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL col_retry got v=%0h instr=%08h exp v=1 instr=deadbeef", if_valid, if_instr);
    end
    // Misaligned loader write in RUN is counted but not written; ld_done ignored
    ld_valid = 1'b1; ld_addr = 32'h6; ld_data = 32'hBAD0_BAD0; ld_done = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL col_misaligned_we got=%0h exp=0", mem_we); end
    tick();
    ld_valid = 1'b0; ld_done = 1'b0;
    checks++; if (boot_words !== 11'd6 || cpu_run !== 1'b1) begin
      failures++; $display("FAIL col_misaligned_cnt got bw=%0d run=%0h exp bw=6 run=1", boot_words, cpu_run);
    end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic        exp_e [3];
    logic [31:0] exp_i [3];
    addrs[0] = 32'h2;    exp_e[0] = 1'b1; exp_i[0] = 32'h0;
    addrs[1] = 32'h1000; exp_e[1] = 1'b1; exp_i[1] = 32'h0;
    addrs[2] = 32'h8;    exp_e[2] = 1'b0; exp_i[2] = 32'h3333_3333;
    for (int i = 0; i < 3; i++) begin
      if_req = 1'b1; if_addr = addrs[i];
      tick();
      checks++; if (if_valid !== 1'b1 || if_err !== exp_e[i] || if_instr !== exp_i[i]) begin
        failures++; $display("FAIL err[%0h] got v=%0h e=%0h instr=%08h exp v=1 e=%0h instr=%08h", addrs[i], if_valid, if_err, if_instr, exp_e[i], exp_i[i]);
      end
    end
    if_req = 1'b0;
    tick();
    checks++; if (if_err !== 1'b0 || if_valid !== 1'b0) begin
      failures++; $display("FAIL err_clear got v=%0h e=%0h exp v=0 e=0", if_valid, if_err);
    end
  endtask

  task automatic test_async_reset();
    if_req = 1'b1; if_addr = 32'h0;
    tick();
    if_addr = 32'h4;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0 || cpu_run !== 1'b0 || boot_words !== 11'd0) begin
      failures++; $display("FAIL arst_now got v=%0h run=%0h bw=%0d exp v=0 run=0 bw=0", if_valid, cpu_run, boot_words);
    end
    tick();
    rst_n = 1'b1;
    if_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_gnt !== 1'b0) begin failures++; $display("FAIL arst_no_gnt[%0d] got=%0h exp=0", i, if_gnt); end
      tick();
    end
    ld_done = 1'b1;
    tick();
    ld_done = 1'b0;
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL arst_reboot got=%0h exp=1", cpu_run); end
    tick();
    if_req = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h1111_1111) begin
      failures++; $display("FAIL arst_mem_kept got v=%0h instr=%08h exp v=1 instr=11111111", if_valid, if_instr);
    end
  endtask

  task automatic test_full_fill();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      ld_valid = 1'b1; ld_addr = 32'(i * 4); ld_data = 32'hA5A5_0000 | 32'(i);
      tick();
      if (i == 1022) begin
        checks++; if (cpu_run !== 1'b0 || boot_words !== 11'd1023) begin
          failures++; $display("FAIL full_1023 got run=%0h bw=%0d exp run=0 bw=1023", cpu_run, boot_words);
        end
      end
    end
    checks++; if (cpu_run !== 1'b1 || boot_words !== 11'd1024) begin
      failures++; $display("FAIL full_1024 got run=%0h bw=%0d exp run=1 bw=1024", cpu_run, boot_words);
    end
    ld_addr = 32'h0; ld_data = 32'h0BAD_F00D;
    tick();
    ld_valid = 1'b0;
    checks++; if (boot_words !== 11'd1024) begin failures++; $display("FAIL full_saturate got=%0d exp=1024", boot_words); end
    if_req = 1'b1; if_addr = 32'hFFC;
    tick();
    checks++; if (if_valid !== 1'b1 || if_err !== 1'b0 || if_instr !== 32'hA5A5_03FF) begin
      failures++; $display("FAIL full_top_word got v=%0h e=%0h instr=%08h exp v=1 e=0 instr=a5a503ff", if_valid, if_err, if_instr);
    end
    if_addr = 32'h0;
    tick();
    if_req = 1'b0;
    checks++; if (if_instr !== 32'h0BAD_F00D) begin failures++; $display("FAIL full_post_write got=%08h exp=0badf00d", if_instr); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_boot_fill();
    test_sequential();
    test_collision();
    test_errors();
    test_async_reset();
    test_full_fill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
